// File: rtl/stream_mixer.sv
// ---------------------------------------------------------------------------
// stream_mixer
//
// Pairs a lowpass and a highpass sample stream, applies a per-stream gain and
// mixes the pair into one saturated 12-bit sample for the DAC serialiser.
// Each side has a one-entry holding register, so the two streams do not have
// to arrive in the same cycle. A lone sample that waits too long for its
// partner is dropped without producing an output.
//
// Parameters
//   PAIR_TIMEOUT      cycles a lone held sample waits for its partner
//   OUT_OFFSET_BINARY 1 = offset-binary output, 0 = two's complement output
//
// Ports
//   clk               sample-domain clock (20 MHz)
//   reset             synchronous, active-high reset
//   lp_data/hp_data   12-bit two's complement input samples
//   lp_valid/hp_valid one-cycle strobes qualifying data and error
//   lp_error/hp_error 2-bit error flags travelling with each sample
//   lp_gain/hp_gain   unsigned gain, units of 1/8
//   ast_source_data   mixed output sample (held between strobes)
//   ast_source_valid  one-cycle strobe per mixed sample
//   ast_source_error  [0] input error or saturation, [1] input error or
//                     overwrite of a held sample
//   sat_count         saturated-output counter, sticks at 255
// ---------------------------------------------------------------------------
module stream_mixer #(
  parameter int PAIR_TIMEOUT      = 16,
  parameter int OUT_OFFSET_BINARY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] lp_data,
  input  logic        lp_valid,
  input  logic [1:0]  lp_error,
  input  logic [11:0] hp_data,
  input  logic        hp_valid,
  input  logic [1:0]  hp_error,
  input  logic [3:0]  lp_gain,
  input  logic [3:0]  hp_gain,
  output logic [11:0] ast_source_data,
  output logic        ast_source_valid,
  output logic [1:0]  ast_source_error,
  output logic [7:0]  sat_count
);

  localparam int unsigned AW = $clog2(PAIR_TIMEOUT + 1);

  // The age register is zeroed at the capture edge, so it reads
  // PAIR_TIMEOUT-1 during the PAIR_TIMEOUT-th cycle the sample is held.
  // That is the cycle whose closing edge discards the entry.
  localparam logic [AW-1:0] AGE_LIM = AW'(PAIR_TIMEOUT - 1);

  localparam logic [11:0]        DATA_RST = (OUT_OFFSET_BINARY != 0) ? 12'h800 : 12'h000;
  localparam logic signed [17:0] SAT_MAX  = 18'sd2047;
  localparam logic signed [17:0] SAT_MIN  = -18'sd2048;

  // -------------------------------------------------------------------------
  // Holding registers
  // -------------------------------------------------------------------------
  logic [11:0]   r_lp_data;
  logic [1:0]    r_lp_err;
  logic          r_lp_held;
  logic          r_lp_ovr;
  logic [AW-1:0] r_lp_age;

  logic [11:0]   r_hp_data;
  logic [1:0]    r_hp_err;
  logic          r_hp_held;
  logic          r_hp_ovr;
  logic [AW-1:0] r_hp_age;

  // -------------------------------------------------------------------------
  // Pairing / launch decode
  // -------------------------------------------------------------------------
  logic          w_lp_avail;
  logic          w_hp_avail;
  logic          w_launch;
  logic          w_lp_drop;
  logic          w_hp_drop;
  logic [11:0]   w_lp_sel;
  logic [11:0]   w_hp_sel;
  logic [1:0]    w_lp_err_sel;
  logic [1:0]    w_hp_err_sel;
  logic          w_lp_ovr_sel;
  logic          w_hp_ovr_sel;

  always_comb begin
    w_lp_avail = r_lp_held | lp_valid;
    w_hp_avail = r_hp_held | hp_valid;
    w_launch   = w_lp_avail & w_hp_avail;

    // A lone entry is dropped only when its partner is absent this cycle.
    w_lp_drop  = r_lp_held & (r_lp_age == AGE_LIM) & ~w_hp_avail;
    w_hp_drop  = r_hp_held & (r_hp_age == AGE_LIM) & ~w_lp_avail;

    // A fresh sample wins over the held one on the same side.
    w_lp_sel     = lp_valid ? lp_data  : r_lp_data;
    w_hp_sel     = hp_valid ? hp_data  : r_hp_data;
    w_lp_err_sel = lp_valid ? lp_error : r_lp_err;
    w_hp_err_sel = hp_valid ? hp_error : r_hp_err;

    // A fresh sample replacing a held one in the launch cycle is itself an
    // overwrite: the held sample never reaches the output.
    w_lp_ovr_sel = r_lp_ovr | (lp_valid & r_lp_held);
    w_hp_ovr_sel = r_hp_ovr | (hp_valid & r_hp_held);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lp_data <= '0;
      r_lp_err  <= '0;
      r_lp_held <= 1'b0;
      r_lp_ovr  <= 1'b0;
      r_lp_age  <= '0;
    end else begin
      if (lp_valid) begin
        r_lp_data <= lp_data;
        r_lp_err  <= lp_error;
      end
      if (w_launch) begin
        r_lp_held <= 1'b0;
        r_lp_ovr  <= 1'b0;
        r_lp_age  <= '0;
      end else if (lp_valid) begin
        r_lp_held <= 1'b1;
        r_lp_ovr  <= r_lp_ovr | r_lp_held;
        r_lp_age  <= '0;
      end else if (w_lp_drop) begin
        r_lp_held <= 1'b0;
        r_lp_ovr  <= 1'b0;
        r_lp_age  <= '0;
      end else if (r_lp_held) begin
        r_lp_age  <= r_lp_age + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hp_data <= '0;
      r_hp_err  <= '0;
      r_hp_held <= 1'b0;
      r_hp_ovr  <= 1'b0;
      r_hp_age  <= '0;
    end else begin
      if (hp_valid) begin
        r_hp_data <= hp_data;
        r_hp_err  <= hp_error;
      end
      if (w_launch) begin
        r_hp_held <= 1'b0;
        r_hp_ovr  <= 1'b0;
        r_hp_age  <= '0;
      end else if (hp_valid) begin
        r_hp_held <= 1'b1;
        r_hp_ovr  <= r_hp_ovr | r_hp_held;
        r_hp_age  <= '0;
      end else if (w_hp_drop) begin
        r_hp_held <= 1'b0;
        r_hp_ovr  <= 1'b0;
        r_hp_age  <= '0;
      end else if (r_hp_held) begin
        r_hp_age  <= r_hp_age + AW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: gain multiply, registered at the launch edge
  // -------------------------------------------------------------------------
  logic signed [16:0] w_lp_op;
  logic signed [16:0] w_hp_op;
  logic signed [16:0] w_lp_gx;
  logic signed [16:0] w_hp_gx;
  logic signed [16:0] w_lp_prod;
  logic signed [16:0] w_hp_prod;

  always_comb begin
    w_lp_op   = {{5{w_lp_sel[11]}}, w_lp_sel};
    w_hp_op   = {{5{w_hp_sel[11]}}, w_hp_sel};
    w_lp_gx   = {13'd0, lp_gain};
    w_hp_gx   = {13'd0, hp_gain};
    w_lp_prod = w_lp_op * w_lp_gx;
    w_hp_prod = w_hp_op * w_hp_gx;
  end

  logic               r_s1_valid;
  logic signed [16:0] r_p_lp;
  logic signed [16:0] r_p_hp;
  logic [1:0]         r_s1_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_p_lp     <= '0;
      r_p_hp     <= '0;
      r_s1_err   <= '0;
    end else begin
      r_s1_valid <= w_launch;
      if (w_launch) begin
        r_p_lp      <= w_lp_prod;
        r_p_hp      <= w_hp_prod;
        r_s1_err[0] <= w_lp_err_sel[0] | w_hp_err_sel[0];
        r_s1_err[1] <= w_lp_err_sel[1] | w_hp_err_sel[1] | w_lp_ovr_sel | w_hp_ovr_sel;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: sum, scale by 1/8, saturate, format
  // -------------------------------------------------------------------------
  logic signed [17:0] w_sum;
  logic signed [17:0] w_shift;
  logic [11:0]        w_sat_val;
  logic               w_sat;
  logic [11:0]        w_out;

  always_comb begin
    w_sum   = {r_p_lp[16], r_p_lp} + {r_p_hp[16], r_p_hp};
    w_shift = w_sum >>> 3;
    if (w_shift > SAT_MAX) begin
      w_sat_val = 12'h7FF;
      w_sat     = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      w_sat_val = 12'h800;
      w_sat     = 1'b1;
    end else begin
      w_sat_val = w_shift[11:0];
      w_sat     = 1'b0;
    end
    w_out = (OUT_OFFSET_BINARY != 0) ? (w_sat_val ^ 12'h800) : w_sat_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ast_source_valid <= 1'b0;
      ast_source_data  <= DATA_RST;
      ast_source_error <= 2'b00;
      sat_count        <= '0;
    end else begin
      ast_source_valid <= r_s1_valid;
      if (r_s1_valid) begin
        ast_source_data  <= w_out;
        ast_source_error <= {r_s1_err[1], r_s1_err[0] | w_sat};
        if (w_sat && (sat_count != 8'hFF)) begin
          sat_count <= sat_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mixer.sv
// ---------------------------------------------------------------------------
// tb_stream_mixer
//
// Table of simultaneous-arrival vectors plus hand-written sequences for
// staggered pairing, overwrite, timeout, reset and sat_count saturation.
// Expected outputs go into a scoreboard queue when stimulus is driven and are
// popped by a negedge monitor when the DUT strobes ast_source_valid.
// ---------------------------------------------------------------------------
module tb_stream_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] lp_data, hp_data;
  logic        lp_valid, hp_valid;
  logic [1:0]  lp_error, hp_error;
  logic [3:0]  lp_gain, hp_gain;
  logic [11:0] ast_source_data;
  logic        ast_source_valid;
  logic [1:0]  ast_source_error;
  logic [7:0]  sat_count;

  stream_mixer #(
    .PAIR_TIMEOUT      (16),
    .OUT_OFFSET_BINARY (1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .lp_data          (lp_data),
    .lp_valid         (lp_valid),
    .lp_error         (lp_error),
    .hp_data          (hp_data),
    .hp_valid         (hp_valid),
    .hp_error         (hp_error),
    .lp_gain          (lp_gain),
    .hp_gain          (hp_gain),
    .ast_source_data  (ast_source_data),
    .ast_source_valid (ast_source_valid),
    .ast_source_error (ast_source_error),
    .sat_count        (sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int sat_model = 0;

  typedef struct {
    int          cyc;
    logic [11:0] data;
    logic [1:0]  err;
    logic [7:0]  sat;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [11:0] lp;
    logic [11:0] hp;
    logic [3:0]  lg;
    logic [3:0]  hg;
    logic [1:0]  le;
    logic [1:0]  he;
    logic [11:0] data;
    logic [1:0]  err;
    bit          sat;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lp_valid = 1'b0;
    hp_valid = 1'b0;
  endtask

  task automatic push(input logic [11:0] data, input logic [1:0] err, input bit sat);
    exp_t e;
    if (sat && sat_model < 255) sat_model++;
    e.cyc  = cyc + 2;
    e.data = data;
    e.err  = err;
    e.sat  = sat_model[7:0];
    sbq.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (ast_source_valid) begin
      n_valid++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 required=0 data=%0h (cycle %0d)", ast_source_data, cyc);
      end else begin
        e = sbq.pop_front();
        chk("latency", cyc, e.cyc);
        chk("out_data", ast_source_data, e.data);
        chk("out_error", ast_source_error, e.err);
        chk("sat_count", sat_count, e.sat);
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_valid actual=0 required=1 expected_cycle=%0d (cycle %0d)", e.cyc, cyc);
    end
  end

  initial begin
    int t0;
    int nv0;

    //            lp       hp      lg  hg  le     he     data     err    sat
    tv[0] = '{12'h100, 12'h000, 8,  0,  2'b00, 2'b00, 12'h900, 2'b00, 0};
    tv[1] = '{12'h555, 12'h2AA, 0,  0,  2'b00, 2'b11, 12'h800, 2'b11, 0};
    tv[2] = '{12'h001, 12'hFFF, 8,  8,  2'b10, 2'b00, 12'h800, 2'b10, 0};
    tv[3] = '{12'h0FF, 12'h003, 3,  5,  2'b01, 2'b00, 12'h861, 2'b01, 0};
    tv[4] = '{12'hFFD, 12'h000, 1,  0,  2'b00, 2'b00, 12'h7FF, 2'b00, 0};
    tv[5] = '{12'h800, 12'h000, 8,  0,  2'b00, 2'b00, 12'h000, 2'b00, 0};
    tv[6] = '{12'h7FF, 12'h7FF, 15, 15, 2'b00, 2'b00, 12'hFFF, 2'b01, 1};
    tv[7] = '{12'h800, 12'h800, 8,  8,  2'b00, 2'b00, 12'h000, 2'b01, 1};
    tv[8] = '{12'h7FF, 12'h000, 8,  0,  2'b00, 2'b00, 12'hFFF, 2'b00, 0};
    tv[9] = '{12'h7FF, 12'h001, 8,  8,  2'b00, 2'b00, 12'hFFF, 2'b01, 1};

    // Reset with live inputs, which must be ignored
    reset    = 1'b1;
    lp_data  = 12'h123; hp_data  = 12'h456;
    lp_error = 2'b11;   hp_error = 2'b11;
    lp_gain  = 4'd8;    hp_gain  = 4'd8;
    lp_valid = 1'b1;    hp_valid = 1'b1;
    repeat (3) step();
    chk("rst_valid", ast_source_valid, 1'b0);
    chk("rst_data", ast_source_data, 12'h800);
    chk("rst_error", ast_source_error, 2'b00);
    chk("rst_sat", sat_count, 8'd0);
    reset = 1'b0;
    idle();
    lp_error = 2'b00; hp_error = 2'b00;
    repeat (4) step();

    // Table vectors, launched back-to-back
    for (int i = 0; i < 10; i++) begin
      lp_data = tv[i].lp;   hp_data = tv[i].hp;
      lp_gain = tv[i].lg;   hp_gain = tv[i].hg;
      lp_error = tv[i].le;  hp_error = tv[i].he;
      lp_valid = 1'b1;      hp_valid = 1'b1;
      push(tv[i].data, tv[i].err, tv[i].sat);
      step();
    end
    idle();
    lp_error = 2'b00; hp_error = 2'b00;
    repeat (5) step();
    chk("hold_valid", ast_source_valid, 1'b0);
    chk("hold_data", ast_source_data, 12'hFFF);

    // Staggered with overwrite; gains are only sampled in the launch cycle
    lp_gain = 4'd0; hp_gain = 4'd0;
    t0 = cyc;
    lp_data = 12'h010; lp_valid = 1'b1;
    step(); idle();
    while (cyc < t0 + 3) step();
    lp_data = 12'h020; lp_valid = 1'b1;
    step(); idle();
    while (cyc < t0 + 5) step();
    lp_gain = 4'd8; hp_gain = 4'd8;
    hp_data = 12'h000; hp_valid = 1'b1;
    push(12'h820, 2'b10, 0);
    step(); idle();
    lp_gain = 4'd0; hp_gain = 4'd0;
    repeat (4) step();

    // Held lp meets hp next cycle; error travels with the held sample
    lp_gain = 4'd8; hp_gain = 4'd8;
    lp_data = 12'h040; lp_error = 2'b01; lp_valid = 1'b1;
    step();
    lp_valid = 1'b0; lp_error = 2'b10;
    hp_data = 12'h008; hp_error = 2'b00; hp_valid = 1'b1;
    push(12'h848, 2'b01, 0);
    step(); idle();
    lp_error = 2'b00;
    repeat (4) step();

    // Timeout boundary: partner in the last held cycle still pairs
    t0 = cyc;
    lp_data = 12'h030; lp_valid = 1'b1;
    step(); idle();
    while (cyc < t0 + 16) step();
    hp_data = 12'h001; hp_valid = 1'b1;
    push(12'h831, 2'b00, 0);
    step(); idle();
    repeat (4) step();

    // Timeout: partner one cycle late is held alone, then also discarded
    nv0 = n_valid;
    t0 = cyc;
    lp_data = 12'h030; lp_valid = 1'b1;
    step(); idle();
    while (cyc < t0 + 17) step();
    hp_data = 12'h001; hp_valid = 1'b1;
    step(); idle();
    repeat (20) step();
    lp_data = 12'h050; lp_valid = 1'b1;
    step(); idle();
    repeat (20) step();
    chk("timeout_no_output", n_valid, nv0);

    // Reset mid-pipeline with a saturating pair in flight
    lp_data = 12'h7FF; hp_data = 12'h7FF;
    lp_gain = 4'd15;   hp_gain = 4'd15;
    lp_valid = 1'b1;   hp_valid = 1'b1;
    step();
    hp_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    lp_valid = 1'b0;
    sat_model = 0;
    chk("midrst_valid", ast_source_valid, 1'b0);
    chk("midrst_data", ast_source_data, 12'h800);
    chk("midrst_sat", sat_count, 8'd0);
    nv0 = n_valid;
    hp_valid = 1'b1;
    step(); idle();
    repeat (6) step();
    chk("midrst_no_output", n_valid, nv0);
    repeat (20) step();

    // sat_count sticks at 255; also exercises back-to-back launches
    lp_data = 12'h7FF; hp_data = 12'h7FF;
    lp_gain = 4'd15;   hp_gain = 4'd15;
    for (int i = 0; i < 260; i++) begin
      lp_valid = 1'b1; hp_valid = 1'b1;
      push(12'hFFF, 2'b01, 1);
      step();
    end
    idle();

    for (int i = 0; i < 10 && sbq.size() > 0; i++) step();
    step();
    chk("scoreboard_drained", sbq.size(), 0);
    chk("sat_final", sat_count, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mixer.md
STREAM_MIXER -- requirements
Module: stream_mixer

Interface
REQ-001 SHALL have parameter PAIR_TIMEOUT, default 16: cycles a lone held sample waits for its partner before it is discarded.
REQ-002 SHALL have parameter OUT_OFFSET_BINARY, default 1: 1 = output is offset binary (DAC format), 0 = output is two's complement.
REQ-003 SHALL have port clk, input, 1: single clock, the 20 MHz sample-domain clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port lp_data, input, 12: lowpass sample, two's complement.
REQ-006 SHALL have port lp_valid, input, 1: one-cycle strobe qualifying lp_data and lp_error.
REQ-007 SHALL have port lp_error, input, 2: lowpass error bits.
REQ-008 SHALL have ports hp_data (input, 12), hp_valid (input, 1) and hp_error (input, 2), with the same meanings for the highpass stream.
REQ-009 SHALL have ports lp_gain and hp_gain, input, 4 each: unsigned gain in units of 1/8.
REQ-010 SHALL have port ast_source_data, output, 12: mixed sample to dac_serial.
REQ-011 SHALL have port ast_source_valid, output, 1: one-cycle strobe per mixed sample.
REQ-012 SHALL have port ast_source_error, output, 2: error bits of the mixed sample.
REQ-013 SHALL have port sat_count, output, 8: count of saturated output samples; it stops at 255 and does not wrap.

Function
REQ-014 Capture: each input SHALL have a one-entry holding register with a held flag, loaded at the clock edge ending any cycle in which that input's valid is high.
REQ-015 Launch: a pair SHALL launch in cycle N when each side is either held or valid in cycle N.
REQ-016 Source selection: a sample arriving in the launch cycle SHALL take precedence over a held value on the same side.
REQ-017 Clear on launch: both held flags SHALL clear at the launch edge.
REQ-018 Overwrite: a valid arriving while that side is already held SHALL replace the held value and set that side's overwrite flag; the flag clears at launch.
REQ-019 Timeout: each held side SHALL have an age counter that is zeroed on capture or overwrite and incremented every cycle while held.
REQ-020 Timeout discard: when the age equals PAIR_TIMEOUT and the partner is neither held nor valid, the held entry SHALL be discarded at the end of that cycle, with no output.
REQ-021 Gain sampling: lp_gain and hp_gain SHALL be sampled in the launch cycle only.
REQ-022 Stage 1, at the launch edge: register p_lp = lp × lp_gain and p_hp = hp × hp_gain, each 17-bit signed.
REQ-023 Stage 2: sum = p_lp + p_hp (18-bit signed), then arithmetic shift right by 3.
REQ-024 Stage 2 saturation: saturate the shifted sum to the range [-2048, 2047].
REQ-025 Latency: ast_source_valid SHALL be high in cycle N+2 for exactly one cycle.
REQ-026 Output format: with OUT_OFFSET_BINARY=1, ast_source_data SHALL be the saturated value XOR 0x800.
REQ-027 Data hold: ast_source_data SHALL hold its value between valid strobes.
REQ-028 Error bit 0: ast_source_error[0] SHALL be lp_error[0] OR hp_error[0] OR saturation occurred.
REQ-029 Error bit 1: ast_source_error[1] SHALL be lp_error[1] OR hp_error[1] OR either overwrite flag.
REQ-030 Error source: the error inputs used SHALL be those captured with the paired samples.
REQ-031 sat_count SHALL increment in the cycle the saturated output is presented.
REQ-032 Back-to-back: the pipeline SHALL accept a new launch every cycle with no stall.
REQ-033 Back-to-back: consecutive launches SHALL produce consecutive valid strobes.

Reset
REQ-034 On reset, held flags, overwrite flags, age counters, pipeline valids and sat_count SHALL go to 0.
REQ-035 On reset, ast_source_valid SHALL go to 0 and ast_source_error to 2'b00.
REQ-036 On reset, ast_source_data SHALL go to 12'h800 when OUT_OFFSET_BINARY=1, else 12'h000.
REQ-037 Reset mid-operation: reset asserted while samples are held or in flight SHALL discard them.
REQ-038 Reset mid-operation: no ast_source_valid SHALL be produced for discarded samples after reset deasserts.
REQ-039 Inputs presented during reset SHALL be ignored.

Verification
REQ-040 Simultaneous: lp=0x100, hp=0x000, gains 8/0, both valid in cycle 0 -> valid in cycle 2 only, data 0x900, error 00.
REQ-041 Positive saturation: lp=hp=0x7FF, gains 15/15 (sum 7676) -> data 0xFFF, error[0]=1, sat_count=1.
REQ-042 Negative saturation: lp=hp=0x800, gains 8/8 (sum -4096) -> data 0x000, error[0]=1, sat_count=2.
REQ-043 Staggered with overwrite: lp=0x010 in cycle 0, lp=0x020 in cycle 3, hp=0x000 in cycle 5, gains 8/8.
  - Expected: valid in cycle 7, data 0x820, error[1]=1.
REQ-044 Timeout: lp valid in cycle 0 only, PAIR_TIMEOUT=16 -> lp discarded end of cycle 16, hp valid in cycle 17 -> held, no output.
REQ-045 Reset mid-pipeline: launch in cycle 0, reset in cycle 1 -> no valid in cycle 2, data 0x800, sat_count 0.
